// File: rtl/ip_rewrite_noc_pipe_pkg.sv
// rtl/ip_rewrite_noc_pipe_pkg.sv - shared types for the IP rewrite NoC pipe
package ip_rewrite_noc_pipe_pkg;

  localparam int FLOW_LOOKUP_TUPLE_W = 64;
  localparam int IP_ADDR_W           = 32;
  localparam int FLOW_INDEX_MAX_W    = 8;

  typedef struct packed {
    logic [31:0] their_addr;
    logic [15:0] their_port;
    logic [15:0] our_port;
  } flow_lookup_tuple_t;

  typedef struct packed {
    logic                  valid;
    flow_lookup_tuple_t    key;
    logic [IP_ADDR_W-1:0]  rewrite_addr;
  } flow_table_entry_t;

  localparam int FLOW_TABLE_ENTRY_W = $bits(flow_table_entry_t);

  typedef struct packed {
    logic                        hit;
    logic [FLOW_INDEX_MAX_W-1:0] index;
    logic [IP_ADDR_W-1:0]        rewrite_addr;
  } flow_lookup_resp_t;

endpackage

// File: rtl/ip_rewrite_flow_match_enc.sv
// rtl/ip_rewrite_flow_match_enc.sv - match vector to {any, lowest matching index}
module ip_rewrite_flow_match_enc #(
  parameter int NUM_ENTRIES = 8,
  parameter int INDEX_W     = $clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES-1:0] match_vec,
  output logic                   any,
  output logic [INDEX_W-1:0]     index
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (match_vec[i]) index = i[INDEX_W-1:0];
    end
  end

  assign any = |match_vec;

endmodule

// File: rtl/ip_rewrite_flow_table.sv
// rtl/ip_rewrite_flow_table.sv - flop-based flow table resolving lookup tuples to rewrite addresses
module ip_rewrite_flow_table
  import ip_rewrite_noc_pipe_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int INDEX_W     = $clog2(NUM_ENTRIES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           src_lookup_req_val,
  input  logic [FLOW_LOOKUP_TUPLE_W-1:0] src_lookup_req_tuple,
  output logic                           lookup_src_req_rdy,
  output logic                           lookup_dst_resp_val,
  output logic                           lookup_dst_resp_hit,
  output logic [INDEX_W-1:0]             lookup_dst_resp_index,
  output logic [IP_ADDR_W-1:0]           lookup_dst_resp_rewrite_addr,
  input  logic                           dst_lookup_resp_rdy,
  input  logic                           cfg_wr_val,
  input  logic [INDEX_W-1:0]             cfg_wr_index,
  input  logic [FLOW_LOOKUP_TUPLE_W-1:0] cfg_wr_tuple,
  input  logic [IP_ADDR_W-1:0]           cfg_wr_rewrite_addr,
  input  logic                           cfg_wr_entry_val,
  output logic                           cfg_wr_rdy,
  input  logic                           cfg_flush,
  output logic [31:0]                    hit_cnt,
  output logic [31:0]                    miss_cnt
);

  flow_table_entry_t      table_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] match_vec;
  logic                   match_any;
  logic [INDEX_W-1:0]     match_index;
  logic                   req_accept;
  logic                   resp_handshake;

  logic                   resp_val_q;
  logic                   resp_hit_q;
  logic [INDEX_W-1:0]     resp_index_q;
  logic [IP_ADDR_W-1:0]   resp_addr_q;
  logic [31:0]            hit_cnt_q;
  logic [31:0]            miss_cnt_q;

  assign lookup_src_req_rdy = !resp_val_q || dst_lookup_resp_rdy;
  assign req_accept         = src_lookup_req_val && lookup_src_req_rdy;
  assign resp_handshake     = resp_val_q && dst_lookup_resp_rdy;
  assign cfg_wr_rdy         = !cfg_flush;

  // Only valid bits are reset; key and address contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) table_q[i].valid <= 1'b0;
    end else if (cfg_flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) table_q[i].valid <= 1'b0;
    end else if (cfg_wr_val) begin
      table_q[cfg_wr_index] <= '{valid:        cfg_wr_entry_val,
                                 key:          cfg_wr_tuple,
                                 rewrite_addr: cfg_wr_rewrite_addr};
    end
  end

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      match_vec[i] = table_q[i].valid && (table_q[i].key == src_lookup_req_tuple);
    end
  end

  ip_rewrite_flow_match_enc #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .INDEX_W     (INDEX_W)
  ) u_match_enc (
    .match_vec (match_vec),
    .any       (match_any),
    .index     (match_index)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_val_q   <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_index_q <= '0;
      resp_addr_q  <= '0;
    end else if (req_accept) begin
      resp_val_q   <= 1'b1;
      resp_hit_q   <= match_any;
      resp_index_q <= match_index;
      resp_addr_q  <= match_any ? table_q[match_index].rewrite_addr : '0;
    end else if (resp_handshake) begin
      resp_val_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (resp_handshake) begin
      if (resp_hit_q) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign lookup_dst_resp_val          = resp_val_q;
  assign lookup_dst_resp_hit          = resp_hit_q;
  assign lookup_dst_resp_index        = resp_index_q;
  assign lookup_dst_resp_rewrite_addr = resp_addr_q;
  assign hit_cnt                      = hit_cnt_q;
  assign miss_cnt                     = miss_cnt_q;

endmodule

// File: tb/tb_ip_rewrite_flow_table.sv
// tb/tb_ip_rewrite_flow_table.sv - self-checking bench for ip_rewrite_flow_table
module tb_ip_rewrite_flow_table;

  localparam int NE = 8;
  localparam int IW = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        src_lookup_req_val;
  logic [63:0] src_lookup_req_tuple;
  logic        lookup_src_req_rdy;
  logic        lookup_dst_resp_val;
  logic        lookup_dst_resp_hit;
  logic [IW-1:0] lookup_dst_resp_index;
  logic [31:0] lookup_dst_resp_rewrite_addr;
  logic        dst_lookup_resp_rdy;
  logic        cfg_wr_val;
  logic [IW-1:0] cfg_wr_index;
  logic [63:0] cfg_wr_tuple;
  logic [31:0] cfg_wr_rewrite_addr;
  logic        cfg_wr_entry_val;
  logic        cfg_wr_rdy;
  logic        cfg_flush;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always #5 clk = ~clk;

  ip_rewrite_flow_table #(.NUM_ENTRIES(NE)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .src_lookup_req_val           (src_lookup_req_val),
    .src_lookup_req_tuple         (src_lookup_req_tuple),
    .lookup_src_req_rdy           (lookup_src_req_rdy),
    .lookup_dst_resp_val          (lookup_dst_resp_val),
    .lookup_dst_resp_hit          (lookup_dst_resp_hit),
    .lookup_dst_resp_index        (lookup_dst_resp_index),
    .lookup_dst_resp_rewrite_addr (lookup_dst_resp_rewrite_addr),
    .dst_lookup_resp_rdy          (dst_lookup_resp_rdy),
    .cfg_wr_val                   (cfg_wr_val),
    .cfg_wr_index                 (cfg_wr_index),
    .cfg_wr_tuple                 (cfg_wr_tuple),
    .cfg_wr_rewrite_addr          (cfg_wr_rewrite_addr),
    .cfg_wr_entry_val             (cfg_wr_entry_val),
    .cfg_wr_rdy                   (cfg_wr_rdy),
    .cfg_flush                    (cfg_flush),
    .hit_cnt                      (hit_cnt),
    .miss_cnt                     (miss_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: table contents, response slot and counters
  bit          m_valid [NE];
  logic [63:0] m_key   [NE];
  logic [31:0] m_addr  [NE];
  bit          m_resp_val;
  bit          m_hit;
  int          m_idx;
  logic [31:0] m_raddr;
  logic [31:0] m_hit_cnt;
  logic [31:0] m_miss_cnt;
  logic [63:0] pool [4];
  logic [36:0] got;
  logic [36:0] exp;

  function automatic logic [63:0] mk(input logic [31:0] a, input logic [15:0] tp, input logic [15:0] op);
    return {a, tp, op};
  endfunction

  task automatic ref_lookup(input logic [63:0] t, output bit h, output int idx, output logic [31:0] a);
    h = 0; idx = 0; a = 32'h0;
    for (int i = 0; i < NE; i++) begin
      if (m_valid[i] && m_key[i] == t) begin
        h = 1; idx = i; a = m_addr[i];
        break;
      end
    end
  endtask

  // Advance one clock, updating the model from the inputs presented this cycle
  task automatic tick();
    bit acc, hs, h;
    int idx;
    logic [31:0] a;
    acc = src_lookup_req_val && (!m_resp_val || dst_lookup_resp_rdy);
    hs  = m_resp_val && dst_lookup_resp_rdy;
    if (hs) begin
      if (m_hit) m_hit_cnt  = (m_hit_cnt  == 32'hFFFF_FFFF) ? m_hit_cnt  : m_hit_cnt + 1;
      else       m_miss_cnt = (m_miss_cnt == 32'hFFFF_FFFF) ? m_miss_cnt : m_miss_cnt + 1;
    end
    if (acc) begin
      ref_lookup(src_lookup_req_tuple, h, idx, a);
      m_resp_val = 1; m_hit = h; m_idx = idx; m_raddr = a;
    end else if (hs) begin
      m_resp_val = 0;
    end
    if (cfg_flush) begin
      for (int i = 0; i < NE; i++) m_valid[i] = 0;
    end else if (cfg_wr_val) begin
      m_valid[cfg_wr_index] = cfg_wr_entry_val;
      m_key[cfg_wr_index]   = cfg_wr_tuple;
      m_addr[cfg_wr_index]  = cfg_wr_rewrite_addr;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    src_lookup_req_val = 0; src_lookup_req_tuple = '0; dst_lookup_resp_rdy = 1;
    cfg_wr_val = 0; cfg_wr_index = '0; cfg_wr_tuple = '0; cfg_wr_rewrite_addr = '0;
    cfg_wr_entry_val = 0; cfg_flush = 0;
  endtask

  task automatic wr_entry(input int idx, input logic [63:0] t, input logic [31:0] a, input bit ev);
    cfg_wr_val = 1; cfg_wr_index = IW'(idx); cfg_wr_tuple = t; cfg_wr_rewrite_addr = a; cfg_wr_entry_val = ev;
    tick();
    cfg_wr_val = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < NE; i++) m_valid[i] = 0;
    m_resp_val = 0; m_hit = 0; m_idx = 0; m_raddr = 0; m_hit_cnt = 0; m_miss_cnt = 0;
    #1;
    got = {lookup_dst_resp_val, lookup_dst_resp_hit, lookup_dst_resp_index, lookup_dst_resp_rewrite_addr};
    total++; if (got !== 37'h0) begin bad++; $display("FAIL reset_resp got=%h exp=0", got); end
    total++; if ({hit_cnt, miss_cnt} !== 64'h0) begin bad++; $display("FAIL reset_cnt got=%h/%h exp=0/0", hit_cnt, miss_cnt); end
    total++; if ({cfg_wr_rdy, lookup_src_req_rdy} !== 2'b11) begin bad++; $display("FAIL reset_rdy got=%b exp=11", {cfg_wr_rdy, lookup_src_req_rdy}); end
  endtask

  task automatic test_basic_hit_miss();
    logic [63:0] t3;
    t3 = mk(32'h0A00_0005, 16'd4000, 16'd80);
    wr_entry(3, t3, 32'h0A00_0063, 1);
    src_lookup_req_val = 1; src_lookup_req_tuple = t3;
    tick();
    src_lookup_req_tuple = mk(32'h0A00_0005, 16'd4000, 16'd81);
    got = {lookup_dst_resp_val, lookup_dst_resp_hit, lookup_dst_resp_index, lookup_dst_resp_rewrite_addr};
    total++; if (got !== {1'b1, 1'b1, 3'd3, 32'h0A00_0063}) begin bad++; $display("FAIL basic_hit got=%h exp=%h", got, {1'b1, 1'b1, 3'd3, 32'h0A00_0063}); end
    tick();
    src_lookup_req_val = 0;
    got = {lookup_dst_resp_val, lookup_dst_resp_hit, lookup_dst_resp_index, lookup_dst_resp_rewrite_addr};
    total++; if (got !== {1'b1, 1'b0, 3'd0, 32'h0}) begin bad++; $display("FAIL basic_miss got=%h exp=%h", got, {1'b1, 1'b0, 3'd0, 32'h0}); end
    total++; if (hit_cnt !== 32'd1) begin bad++; $display("FAIL basic_hit_cnt got=%0d exp=1", hit_cnt); end
    tick();
    total++; if (miss_cnt !== 32'd1 || lookup_dst_resp_val !== 1'b0) begin bad++; $display("FAIL basic_miss_cnt got=%0d/%b exp=1/0", miss_cnt, lookup_dst_resp_val); end
  endtask

  task automatic test_priority();
    logic [63:0] kp;
    kp = mk(32'hC0A8_0001, 16'd1234, 16'd443);
    wr_entry(5, kp, 32'h0000_0055, 1);
    wr_entry(2, kp, 32'h0000_0022, 1);
    src_lookup_req_val = 1; src_lookup_req_tuple = kp;
    tick();
    src_lookup_req_val = 0;
    got = {lookup_dst_resp_val, lookup_dst_resp_hit, lookup_dst_resp_index, lookup_dst_resp_rewrite_addr};
    total++; if (got !== {1'b1, 1'b1, 3'd2, 32'h22}) begin bad++; $display("FAIL prio_low got=%h exp=%h", got, {1'b1, 1'b1, 3'd2, 32'h22}); end
    wr_entry(2, kp, 32'h0000_0022, 0);
    src_lookup_req_val = 1;
    tick();
    src_lookup_req_val = 0;
    got = {lookup_dst_resp_val, lookup_dst_resp_hit, lookup_dst_resp_index, lookup_dst_resp_rewrite_addr};
    total++; if (got !== {1'b1, 1'b1, 3'd5, 32'h55}) begin bad++; $display("FAIL prio_delete got=%h exp=%h", got, {1'b1, 1'b1, 3'd5, 32'h55}); end
    tick();
  endtask

  task automatic test_same_cycle_write();
    logic [63:0] k0;
    k0 = mk(32'hAC10_0009, 16'd5555, 16'd22);
    cfg_wr_val = 1; cfg_wr_index = 0; cfg_wr_tuple = k0; cfg_wr_rewrite_addr = 32'hDEAD_0000; cfg_wr_entry_val = 1;
    src_lookup_req_val = 1; src_lookup_req_tuple = k0;
    tick();
    cfg_wr_val = 0;
    got = {lookup_dst_resp_val, lookup_dst_resp_hit, lookup_dst_resp_index, lookup_dst_resp_rewrite_addr};
    total++; if (got !== {1'b1, 1'b0, 3'd0, 32'h0}) begin bad++; $display("FAIL same_cycle_wr got=%h exp=%h", got, {1'b1, 1'b0, 3'd0, 32'h0}); end
    tick();
    src_lookup_req_val = 0;
    got = {lookup_dst_resp_val, lookup_dst_resp_hit, lookup_dst_resp_index, lookup_dst_resp_rewrite_addr};
    total++; if (got !== {1'b1, 1'b1, 3'd0, 32'hDEAD_0000}) begin bad++; $display("FAIL next_cycle_wr got=%h exp=%h", got, {1'b1, 1'b1, 3'd0, 32'hDEAD_0000}); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0] r [3];
    logic [36:0] e [3];
    bit h; int idx; logic [31:0] a;
    wr_entry(6, mk(32'h0808_0808, 16'd53, 16'd1000), 32'h0000_0066, 1);
    r[0] = mk(32'h0808_0808, 16'd53, 16'd1000);
    r[1] = mk(32'h0808_0808, 16'd53, 16'd1001);
    r[2] = mk(32'h0A00_0005, 16'd4000, 16'd80);
    for (int i = 0; i < 3; i++) begin
      ref_lookup(r[i], h, idx, a);
      e[i] = {1'b1, h, 3'(idx), a};
    end
    dst_lookup_resp_rdy = 0; src_lookup_req_val = 1; src_lookup_req_tuple = r[0];
    tick();
    src_lookup_req_tuple = r[1];
    for (int c = 0; c < 4; c++) begin
      got = {lookup_dst_resp_val, lookup_dst_resp_hit, lookup_dst_resp_index, lookup_dst_resp_rewrite_addr};
      total++; if (got !== e[0] || lookup_src_req_rdy !== 1'b0) begin bad++; $display("FAIL bp_hold c=%0d got=%h rdy=%b exp=%h rdy=0", c, got, lookup_src_req_rdy, e[0]); end
      tick();
    end
    got = {lookup_dst_resp_val, lookup_dst_resp_hit, lookup_dst_resp_index, lookup_dst_resp_rewrite_addr};
    total++; if (got !== e[0]) begin bad++; $display("FAIL bp_resp0 got=%h exp=%h", got, e[0]); end
    dst_lookup_resp_rdy = 1;
    for (int i = 1; i < 3; i++) begin
      tick();
      if (i == 1) src_lookup_req_tuple = r[2];
      else        src_lookup_req_val = 0;
      got = {lookup_dst_resp_val, lookup_dst_resp_hit, lookup_dst_resp_index, lookup_dst_resp_rewrite_addr};
      total++; if (got !== e[i]) begin bad++; $display("FAIL bp_resp%0d got=%h exp=%h", i, got, e[i]); end
    end
    src_lookup_req_val = 0;
    tick();
    total++; if (lookup_dst_resp_val !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", lookup_dst_resp_val); end
    total++; if ({hit_cnt, miss_cnt} !== {m_hit_cnt, m_miss_cnt}) begin bad++; $display("FAIL bp_cnt got=%0d/%0d exp=%0d/%0d", hit_cnt, miss_cnt, m_hit_cnt, m_miss_cnt); end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 4; i++) pool[i] = {$urandom, $urandom};
    for (int c = 0; c < 400; c++) begin
      src_lookup_req_val   = ($urandom_range(0, 9) < 7);
      src_lookup_req_tuple = ($urandom_range(0, 4) == 0) ? {$urandom, $urandom} : pool[$urandom_range(0, 3)];
      dst_lookup_resp_rdy  = ($urandom_range(0, 9) < 7);
      cfg_wr_val           = ($urandom_range(0, 4) == 0);
      cfg_wr_index         = IW'($urandom_range(0, NE - 1));
      cfg_wr_tuple         = pool[$urandom_range(0, 3)];
      cfg_wr_rewrite_addr  = $urandom;
      cfg_wr_entry_val     = ($urandom_range(0, 4) != 0);
      cfg_flush            = ($urandom_range(0, 39) == 0);
      #1;
      total++;
      if (lookup_src_req_rdy !== (!m_resp_val || dst_lookup_resp_rdy) || cfg_wr_rdy !== !cfg_flush) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_rdy c=%0d got=%b%b exp=%b%b", c, lookup_src_req_rdy, cfg_wr_rdy, !m_resp_val || dst_lookup_resp_rdy, !cfg_flush);
      end
      tick();
      got = {lookup_dst_resp_val, lookup_dst_resp_hit, lookup_dst_resp_index, lookup_dst_resp_rewrite_addr};
      exp = {m_resp_val, m_hit, 3'(m_idx), m_raddr};
      total++;
      if (got !== exp || hit_cnt !== m_hit_cnt || miss_cnt !== m_miss_cnt) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_resp c=%0d got=%h %0d/%0d exp=%h %0d/%0d", c, got, hit_cnt, miss_cnt, exp, m_hit_cnt, m_miss_cnt);
      end
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_saturation();
    logic [63:0] ks;
    ks = mk(32'h7F00_0001, 16'd9999, 16'd7777);
    wr_entry(1, ks, 32'h0000_0011, 1);
    tick();
    force dut.hit_cnt_q = 32'hFFFF_FFFE;
    release dut.hit_cnt_q;
    m_hit_cnt = 32'hFFFF_FFFE;
    src_lookup_req_val = 1; src_lookup_req_tuple = ks;
    repeat (3) tick();
    src_lookup_req_val = 0;
    tick();
    total++; if (hit_cnt !== 32'hFFFF_FFFE + 32'd1 || hit_cnt !== m_hit_cnt) begin bad++; $display("FAIL hit_sat got=%h exp=ffffffff", hit_cnt); end
    tick();
    total++; if (hit_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL hit_sat_hold got=%h exp=ffffffff", hit_cnt); end
  endtask

  task automatic test_flush();
    logic [63:0] kf, kf2;
    kf  = mk(32'h0101_0101, 16'd11, 16'd12);
    kf2 = mk(32'h0202_0202, 16'd21, 16'd22);
    wr_entry(4, kf, 32'h0000_0044, 1);
    wr_entry(7, kf2, 32'h0000_0077, 1);
    cfg_flush = 1;
    cfg_wr_val = 1; cfg_wr_index = 2; cfg_wr_tuple = kf2; cfg_wr_rewrite_addr = 32'h0000_0020; cfg_wr_entry_val = 1;
    src_lookup_req_val = 1; src_lookup_req_tuple = kf;
    #1;
    total++; if (cfg_wr_rdy !== 1'b0) begin bad++; $display("FAIL flush_wr_rdy got=%b exp=0", cfg_wr_rdy); end
    tick();
    cfg_flush = 0; cfg_wr_val = 0;
    src_lookup_req_tuple = kf2;
    got = {lookup_dst_resp_val, lookup_dst_resp_hit, lookup_dst_resp_index, lookup_dst_resp_rewrite_addr};
    total++; if (got !== {1'b1, 1'b1, 3'd4, 32'h44}) begin bad++; $display("FAIL flush_preview got=%h exp=%h", got, {1'b1, 1'b1, 3'd4, 32'h44}); end
    #1;
    total++; if (cfg_wr_rdy !== 1'b1) begin bad++; $display("FAIL flush_rdy_back got=%b exp=1", cfg_wr_rdy); end
    for (int i = 0; i < 6; i++) begin
      tick();
      src_lookup_req_tuple = (i < 2) ? kf : pool[i - 2];
      got = {lookup_dst_resp_val, lookup_dst_resp_hit, lookup_dst_resp_index, lookup_dst_resp_rewrite_addr};
      total++; if (got !== {1'b1, 1'b0, 3'd0, 32'h0}) begin bad++; $display("FAIL flush_miss%0d got=%h exp=%h", i, got, {1'b1, 1'b0, 3'd0, 32'h0}); end
    end
    src_lookup_req_val = 0;
    tick();
    total++; if (miss_cnt !== m_miss_cnt) begin bad++; $display("FAIL flush_miss_cnt got=%0d exp=%0d", miss_cnt, m_miss_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_hit_miss();
    test_priority();
    test_same_cycle_write();
    test_back_to_back();
    test_random();
    test_saturation();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
